sign_ext: RTL and testbench



---
 rtl/sign_ext.sv | 38 +++
 tb/tb_sign_ext.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sign_ext.sv
// rtl/sign_ext.sv - two's-complement sign extender, N to M bits
// Combinational widened value and sign flag, plus a one-cycle registered copy.
module sign_ext #(
    parameter int N = 4,
    parameter int M = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_x,
    output logic [M-1:0] o_y,
    output logic [M-1:0] o_y_q,
    output logic         o_neg
);

    // Widening only; a narrower output would silently truncate, so refuse to build.
    generate
        if (N < 1) begin : g_bad_n
            $fatal(1, "sign_ext: N (%0d) must be at least 1", N);
        end else if (M < N) begin : g_bad_m
            $fatal(1, "sign_ext: M (%0d) must be >= N (%0d)", M, N);
        end else if (M == N) begin : g_pass
            assign o_y = i_x;
        end else begin : g_ext
            assign o_y = {{(M-N){i_x[N-1]}}, i_x};
        end
    endgenerate

    assign o_neg = i_x[N-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_y_q <= '0;
        end else begin
            o_y_q <= o_y;
        end
    end

endmodule

// File: tb/tb_sign_ext.sv
// tb/tb_sign_ext.sv - randomized self-checking bench for sign_ext
module tb_sign_ext;

    logic       i_clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       i_rst = 1'b0;

    logic [3:0] x4 = '0;
    logic [5:0] y4, y4_q;
    logic       neg4;

    logic [7:0] x8 = '0;
    logic [7:0] y8, y8_q;
    logic       neg8;

    logic [0:0] x1 = '0;
    logic [7:0] y1, y1_q;
    logic       neg1;

    int errors = 0;
    int checks = 0;

    sign_ext #(.N(4), .M(6)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(x4),
        .o_y(y4), .o_y_q(y4_q), .o_neg(neg4)
    );

    sign_ext #(.N(8), .M(8)) u_dut_eq (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(x8),
        .o_y(y8), .o_y_q(y8_q), .o_neg(neg8)
    );

    sign_ext #(.N(1), .M(8)) u_dut_one (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(x1),
        .o_y(y1), .o_y_q(y1_q), .o_neg(neg1)
    );

    // Clock only toggles while enabled so the combinational sweep runs with it idle.
    always begin
        #5;
        if (clk_run) i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: read x as an n-bit signed integer, then write it back as m-bit two's complement.
    function automatic logic [63:0] model(input int n, input int m, input logic [63:0] x);
        longint u, v, full_n, mask_m;
        full_n = longint'(1) << n;
        mask_m = (longint'(1) << m) - 1;
        u = longint'(x) & (full_n - 1);
        v = (u >= (full_n >> 1)) ? u - full_n : u;
        return 64'(v & mask_m);
    endfunction

    function automatic logic model_neg(input int n, input logic [63:0] x);
        longint u;
        u = longint'(x) & ((longint'(1) << n) - 1);
        return (u >= (longint'(1) << (n - 1)));
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    logic [5:0] exp_q;

    initial begin
        // Combinational sweep with no clock running
        for (int v = 0; v < 16; v++) begin
            x4 = 4'(v);
            #1;
            check($sformatf("comb_y x=%h", v), 64'(y4), model(4, 6, 64'(v)));
            check($sformatf("comb_neg x=%h", v), 64'(neg4), 64'(model_neg(4, 64'(v))));
        end
        x4 = 4'b0111; #1; check("y_0111", 64'(y4), 64'h07);
        x4 = 4'b1000; #1; check("y_1000", 64'(y4), 64'h38);
        x4 = 4'b1001; #1; check("y_1001", 64'(y4), 64'h39);

        // Equal-width and single-bit corners
        x8 = 8'h80; #1; check("eq_80", 64'(y8), 64'h80); check("eq_80_neg", 64'(neg8), 64'd1);
        x8 = 8'h7F; #1; check("eq_7f", 64'(y8), 64'h7F); check("eq_7f_neg", 64'(neg8), 64'd0);
        x1 = 1'b1;  #1; check("one_1", 64'(y1), 64'hFF); check("one_1_neg", 64'(neg1), 64'd1);
        x1 = 1'b0;  #1; check("one_0", 64'(y1), 64'h00); check("one_0_neg", 64'(neg1), 64'd0);

        for (int i = 0; i < 20; i++) begin
            x4 = 4'($urandom);
            x8 = 8'($urandom);
            x1 = 1'($urandom);
            #1;
            check("rnd_y4", 64'(y4), model(4, 6, 64'(x4)));
            check("rnd_y8", 64'(y8), model(8, 8, 64'(x8)));
            check("rnd_y1", 64'(y1), model(1, 8, 64'(x1)));
        end

        // Registered path
        clk_run = 1'b1;
        i_rst = 1'b1;
        x4 = 4'($urandom);
        tick();
        tick();
        check("rst_q", 64'(y4_q), 64'h00);
        check("rst_q_eq", 64'(y8_q), 64'h00);
        check("rst_q_one", 64'(y1_q), 64'h00);

        i_rst = 1'b0;
        x4 = 4'b1010;
        tick();
        check("q_1010", 64'(y4_q), 64'h3A);
        x4 = 4'b0101;
        tick();
        check("q_0101", 64'(y4_q), 64'h05);
        x4 = 4'b1010;
        tick();
        check("q_1010_again", 64'(y4_q), 64'h3A);

        // Reset mid-stream clears the register but leaves the combinational path alone
        i_rst = 1'b1;
        x4 = 4'b1111;
        tick();
        check("midrst_q", 64'(y4_q), 64'h00);
        check("midrst_y", 64'(y4), 64'h3F);
        check("midrst_neg", 64'(neg4), 64'd1);
        i_rst = 1'b0;
        tick();
        check("after_rst_q", 64'(y4_q), 64'h3F);

        // Random stream with occasional resets
        for (int i = 0; i < 40; i++) begin
            x4 = 4'($urandom);
            x8 = 8'($urandom);
            i_rst = ($urandom_range(0, 7) == 0);
            exp_q = i_rst ? 6'h00 : 6'(model(4, 6, 64'(x4)));
            tick();
            check("rnd_q4", 64'(y4_q), 64'(exp_q));
            check("rnd_q8", 64'(y8_q), i_rst ? 64'h00 : model(8, 8, 64'(x8)));
            check("rnd_y4_clk", 64'(y4), model(4, 6, 64'(x4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
